avalon_pwm_controller: RTL and testbench

Multi-channel, parametrised PWM generator on an Avalon-MM slave, for LCD backlight dimming and other duty-controlled outputs in the Nios II system. Successor to the single 8-bit duty-latch PIO: a shared prescaler and period counter drive CHANNELS comparators. Period and duty writes are double-buffered and take effect only at period boundaries, so outputs never glitch. An optional period-end interrupt is provided.

---
 rtl/avalon_pwm_pkg.sv | 22 ++
 rtl/avalon_pwm_channel.sv | 38 +++
 rtl/avalon_pwm_controller.sv | 164 ++++++++++++++++
 tb/tb_avalon_pwm_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pwm_pkg.sv
// avalon_pwm_pkg: register map and bit positions shared by the PWM controller
// and its per-channel slice.
// Ports: none (constants only).
package avalon_pwm_pkg;

  // Word addresses on the Avalon-MM slave
  localparam logic [3:0] ADDR_CTRL      = 4'd0;
  localparam logic [3:0] ADDR_PRESCALE  = 4'd1;
  localparam logic [3:0] ADDR_PERIOD    = 4'd2;
  localparam logic [3:0] ADDR_STATUS    = 4'd3;
  localparam logic [3:0] ADDR_DUTY_BASE = 4'd4;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_POL_LSB = 8;

  // STATUS bit positions
  localparam int STATUS_DONE    = 0;
  localparam int STATUS_PENDING = 1;

endpackage

// File: rtl/avalon_pwm_channel.sv
// pwm_channel: one PWM output slice. Holds the duty shadow (written by the
// bus), the active duty (loaded at period boundaries) and the registered
// compare output.
// Ports: clk/reset_n; cnt shared period count; load copies shadow to active;
// enable/pol from CTRL; duty_wr/duty_wdata bus write; duty_shadow readback;
// pwm registered output.
module pwm_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cnt,
  input  logic             load,
  input  logic             enable,
  input  logic             pol,
  input  logic             duty_wr,
  input  logic [WIDTH-1:0] duty_wdata,
  output logic [WIDTH-1:0] duty_shadow,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_act;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      duty_shadow <= '0;
      duty_act    <= '0;
      pwm         <= 1'b0;
    end else begin
      if (duty_wr) duty_shadow <= duty_wdata;
      // A write coinciding with load still lands in the shadow; the active
      // register takes the pre-write shadow value.
      if (load) duty_act <= duty_shadow;
      pwm <= enable ? ((cnt < duty_act) ^ pol) : pol;
    end
  end

endmodule

// File: rtl/avalon_pwm_controller.sv
// avalon_pwm_controller: multi-channel PWM generator on an Avalon-MM slave.
// Shared prescaler and period counter, double-buffered period/duty that
// apply at period wrap, sticky period-done status with level interrupt.
// Ports: clk, reset_n (sync, active-low); address/chipselect/write_n/
// writedata/readdata bus (zero wait states, combinational read);
// pwm_out[CHANNELS] registered outputs; irq level interrupt.
module avalon_pwm_controller
  import avalon_pwm_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);

  logic                      wr;
  logic                      ctrl_en;
  logic                      irq_en;
  logic [CHANNELS-1:0]       pol;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] pre;
  logic [WIDTH-1:0]          period_shadow;
  logic [WIDTH-1:0]          period_act;
  logic [WIDTH-1:0]          cnt;
  logic                      period_done;
  logic                      update_pending;
  logic                      tick;
  logic                      wrap;
  logic                      load;
  logic                      period_wr;
  logic [CHANNELS-1:0]       duty_wr;
  logic [WIDTH-1:0]          duty_shadow [CHANNELS];
  logic                      unused_wdata;

  assign wr        = chipselect && !write_n;
  assign period_wr = wr && (address == ADDR_PERIOD);
  assign tick      = ctrl_en && (pre == prescale);
  assign wrap      = tick && (cnt == period_act);
  // While disabled the active registers track the shadows continuously.
  assign load      = !ctrl_en || wrap;
  assign irq       = irq_en && period_done;

  // Only the low bits of writedata are architected; fold the rest away.
  assign unused_wdata = ^writedata;

  // CTRL, PRESCALE, PERIOD shadow/active
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en       <= 1'b0;
      irq_en        <= 1'b0;
      pol           <= '0;
      prescale      <= '0;
      period_shadow <= '0;
      period_act    <= '0;
    end else begin
      if (wr && address == ADDR_CTRL) begin
        ctrl_en <= writedata[CTRL_EN];
        irq_en  <= writedata[CTRL_IRQ_EN];
        pol     <= writedata[CTRL_POL_LSB +: CHANNELS];
      end
      if (wr && address == ADDR_PRESCALE) prescale <= writedata[PRESCALE_WIDTH-1:0];
      if (period_wr) period_shadow <= writedata[WIDTH-1:0];
      if (load) period_act <= period_shadow;
    end
  end

  // Prescaler: >= so that lowering N below the current count wraps at once
  // without producing a tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (!ctrl_en || pre >= prescale) begin
      pre <= '0;
    end else begin
      pre <= pre + PRESCALE_WIDTH'(1);
    end
  end

  // Period counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!ctrl_en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == period_act) ? '0 : cnt + WIDTH'(1);
    end
  end

  // STATUS: set wins over clear; a shadow write wins over the wrap clear so
  // that a write on the wrap cycle stays pending for the following period.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_done    <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      if (wrap) begin
        period_done <= 1'b1;
      end else if (wr && address == ADDR_STATUS && writedata[STATUS_DONE]) begin
        period_done <= 1'b0;
      end

      if (!ctrl_en) begin
        update_pending <= 1'b0;
      end else if (period_wr || (|duty_wr)) begin
        update_pending <= 1'b1;
      end else if (wrap) begin
        update_pending <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [3:0] DUTY_ADDR = ADDR_DUTY_BASE + 4'(g);

    assign duty_wr[g] = wr && (address == DUTY_ADDR);

    pwm_channel #(.WIDTH(WIDTH)) u_channel (
      .clk         (clk),
      .reset_n     (reset_n),
      .cnt         (cnt),
      .load        (load),
      .enable      (ctrl_en),
      .pol         (pol[g]),
      .duty_wr     (duty_wr[g]),
      .duty_wdata  (writedata[WIDTH-1:0]),
      .duty_shadow (duty_shadow[g]),
      .pwm         (pwm_out[g])
    );
  end

  // Read mux, zero wait states
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_EN]                  = ctrl_en;
        readdata[CTRL_IRQ_EN]              = irq_en;
        readdata[CTRL_POL_LSB +: CHANNELS] = pol;
      end
      ADDR_PRESCALE: readdata[PRESCALE_WIDTH-1:0] = prescale;
      ADDR_PERIOD:   readdata[WIDTH-1:0]          = period_shadow;
      ADDR_STATUS: begin
        readdata[STATUS_DONE]    = period_done;
        readdata[STATUS_PENDING] = update_pending;
      end
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (address == ADDR_DUTY_BASE + 4'(i)) readdata[WIDTH-1:0] = duty_shadow[i];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_pwm_controller.sv
module tb_avalon_pwm_controller;
  import avalon_pwm_pkg::*;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [3:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [31:0]   readdata;
  logic [CH-1:0] pwm_out;
  logic          irq;

  avalon_pwm_controller #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwm_out    (pwm_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd_q[$];
  bit          pwm_q[$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write is taken on the next rising edge; returns 1ns after it.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Combinational read compared against the oldest queued expectation.
  task automatic rd_check(input string name, input logic [3:0] a);
    logic [31:0] exp;
    address = a;
    #1;
    if (rd_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no expected read value queued", name);
    end else begin
      exp = rd_q.pop_front();
      check(name, readdata, exp);
    end
  endtask

  task automatic push_bits(input bit v, input int k);
    for (int i = 0; i < k; i++) pwm_q.push_back(v);
  endtask

  // Expected channel-0 waveform: each count value lasts N+1 clocks and is
  // active while count < duty.
  task automatic push_wave(input int p, input int n, input int d, input bit pl, input int nper);
    for (int per = 0; per < nper; per++)
      for (int c = 0; c <= p; c++)
        for (int r = 0; r <= n; r++)
          pwm_q.push_back((c < d) ^ pl);
  endtask

  // One expected sample per clock, taken on the falling edge.
  task automatic drain(input string name);
    bit exp;
    while (pwm_q.size() > 0) begin
      @(negedge clk);
      exp = pwm_q.pop_front();
      check(name, {31'b0, pwm_out[0]}, {31'b0, exp});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ADDR_CTRL,            32'hFFFF_FFFE, 32'h0000_0F02};
    vecs[1] = '{ADDR_PRESCALE,        32'hFFFF_FF05, 32'h0000_0005};
    vecs[2] = '{ADDR_PERIOD,          32'h1234_ABCD, 32'h0000_ABCD};
    vecs[3] = '{ADDR_DUTY_BASE,       32'hDEAD_0011, 32'h0000_0011};
    vecs[4] = '{ADDR_DUTY_BASE + 4'd3, 32'h0000_FFFF, 32'h0000_FFFF};
    vecs[5] = '{ADDR_STATUS,          32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{4'd8,                 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{4'd15,                32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{ADDR_CTRL,            32'h0000_0000, 32'h0000_0000};

    // ---- Reset with writes pending, mid-period ----
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wr(ADDR_PERIOD, 32'd9);
    wr(ADDR_DUTY_BASE, 32'd3);
    wr(ADDR_CTRL, 32'd3);
    repeat (25) @(posedge clk);
    #1;
    reset_n = 1'b0; chipselect = 1'b1; write_n = 1'b0;
    address = ADDR_CTRL; writedata = 32'h0000_0F03;
    @(posedge clk);
    @(negedge clk);
    check("reset pwm_out", {28'b0, pwm_out}, 32'h0);
    check("reset irq", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd_q.push_back(32'h0);
      rd_check($sformatf("reset read addr %0d", a), 4'(a));
    end

    // ---- Register map table ----
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd_q.push_back(vecs[i].rexp);
      rd_check($sformatf("regmap vec %0d", i), vecs[i].addr);
    end
    rd_q.push_back(32'h0000_0011);
    rd_check("duty0 after stray writes", ADDR_DUTY_BASE);

    // ---- Basic: N=0, P=9, D=3 ----
    wr(ADDR_PRESCALE, 32'd0);
    wr(ADDR_PERIOD, 32'd9);
    wr(ADDR_DUTY_BASE, 32'd3);
    wr(ADDR_DUTY_BASE + 4'd3, 32'd10);
    wr(ADDR_CTRL, 32'd1);
    push_bits(1'b0, 1);
    push_wave(9, 0, 3, 1'b0, 3);
    drain("basic wave");
    check("basic other channels", {29'b0, pwm_out[3:1]}, 32'h4);

    // ---- Prescaler: N=1, P=3, D=2 ----
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_PRESCALE, 32'd1);
    wr(ADDR_PERIOD, 32'd3);
    wr(ADDR_DUTY_BASE, 32'd2);
    wr(ADDR_CTRL, 32'd1);
    push_bits(1'b0, 1);
    push_wave(3, 1, 2, 1'b0, 2);
    drain("prescale wave");

    // ---- Shadow update and write on the wrap cycle ----
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_STATUS, 32'd1);
    wr(ADDR_PRESCALE, 32'd0);
    wr(ADDR_PERIOD, 32'd9);
    wr(ADDR_DUTY_BASE, 32'd3);
    wr(ADDR_CTRL, 32'd1);
    push_bits(1'b0, 1); push_bits(1'b1, 1);
    drain("shadow start");
    wr(ADDR_DUTY_BASE, 32'd7);               // while cnt == 1
    rd_q.push_back(32'h2);
    rd_check("status pending after write", ADDR_STATUS);
    push_bits(1'b1, 2); push_bits(1'b0, 6);
    drain("shadow period1");
    rd_q.push_back(32'h2);
    rd_check("status pending before wrap", ADDR_STATUS);
    push_bits(1'b0, 1);
    drain("shadow wrap1");
    rd_q.push_back(32'h1);
    rd_check("status after wrap1", ADDR_STATUS);
    push_bits(1'b1, 7); push_bits(1'b0, 2);
    drain("shadow period2");
    wr(ADDR_DUTY_BASE, 32'd5);               // lands on the wrap edge
    rd_q.push_back(32'h3);
    rd_check("status wrap-cycle write", ADDR_STATUS);
    push_bits(1'b0, 1); push_bits(1'b1, 7); push_bits(1'b0, 2);
    drain("shadow period3");
    rd_q.push_back(32'h3);
    rd_check("status pending period3", ADDR_STATUS);
    push_bits(1'b0, 1); push_bits(1'b1, 5); push_bits(1'b0, 5);
    drain("shadow period4");
    rd_q.push_back(32'h1);
    rd_check("status after wrap3", ADDR_STATUS);

    // ---- Extremes ----
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_DUTY_BASE, 32'd10);
    wr(ADDR_CTRL, 32'd1);
    push_bits(1'b0, 1); push_bits(1'b1, 25);
    drain("duty above period");
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_DUTY_BASE, 32'd0);
    wr(ADDR_CTRL, 32'd1);
    push_bits(1'b0, 26);
    drain("duty zero");

    // ---- Polarity and disable ----
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_DUTY_BASE, 32'd3);
    wr(ADDR_CTRL, 32'h100);
    wr(ADDR_CTRL, 32'h101);
    push_bits(1'b1, 1);
    push_wave(9, 0, 3, 1'b1, 2);
    drain("inverted wave");
    wr(ADDR_CTRL, 32'h100);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("disable polarity level", {31'b0, pwm_out[0]}, 32'h1);
    end

    // ---- IRQ ----
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_STATUS, 32'd1);
    wr(ADDR_PERIOD, 32'd3);
    wr(ADDR_DUTY_BASE, 32'd1);
    wr(ADDR_CTRL, 32'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("irq before wrap", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq after wrap", {31'b0, irq}, 32'h1);
    wr(ADDR_STATUS, 32'd1);
    check("irq cleared", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    wr(ADDR_STATUS, 32'd1);                  // clear on the wrap edge
    check("irq set wins over clear", {31'b0, irq}, 32'h1);
    rd_q.push_back(32'h1);
    rd_check("status set wins", ADDR_STATUS);
    wr(ADDR_CTRL, 32'd1);
    check("irq masked by irq_en", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
